// File: rtl/spi_reg_pkg.sv
// spi_reg_pkg: command codes, register map, reset values and FSM states shared by spi_reg_slave.
package spi_reg_pkg;
    localparam logic [7:0] CMD_WRITE   = 8'h01;
    localparam logic [7:0] CMD_READ    = 8'h02;
    localparam logic [7:0] ADDR_LED    = 8'd0;
    localparam logic [7:0] ADDR_BLINK  = 8'd1;
    localparam logic [7:0] ADDR_CTRL   = 8'd2;
    localparam logic [7:0] ADDR_STATUS = 8'd3;
    localparam logic [7:0] BLINK_RST   = 8'h19;
    localparam logic [7:0] CTRL_RST    = 8'h01;
    typedef enum logic [2:0] {ST_IDLE, ST_CMD, ST_ADDR, ST_DATA, ST_HOLD} state_t;
endpackage

// File: rtl/spi_sync_edge.sv
// spi_sync_edge: STAGES-deep synchronizer for one async input, with rise/fall pulses in the clk domain.
module spi_sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o,
    output logic rise_o,
    output logic fall_o
);
    // One extra flop beyond the synchronizer holds the previous level for edge detection.
    logic [STAGES:0] sr_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sr_q <= '0;
        else        sr_q <= {sr_q[STAGES-1:0], d_i};
    end
    assign q_o    = sr_q[STAGES-1];
    assign rise_o = sr_q[STAGES-1] & ~sr_q[STAGES];
    assign fall_o = ~sr_q[STAGES-1] & sr_q[STAGES];
endmodule

// File: rtl/spi_reg_slave.sv
// spi_reg_slave: SPI mode-0 slave with LED_PATTERN/BLINK_DIV/CTRL/STATUS registers.
// Define SPI_REG_SLAVE_READBACK_EN to enable the READ command and MISO read data.
module spi_reg_slave
    import spi_reg_pkg::*;
#(
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] LED_RST     = 8'h01
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       spi_cs,
    input  logic       spi_sck,
    input  logic       spi_mosi,
    output logic       spi_miso,
    output logic [7:0] led_pattern,
    output logic [7:0] blink_div,
    output logic [7:0] ctrl,
    output logic       wr_strobe,
    output logic [1:0] wr_addr
);
    logic cs_q, cs_rise, cs_fall, sck_q, sck_rise, sck_fall, mosi_q, mosi_rise, mosi_fall;
    spi_sync_edge #(.STAGES(SYNC_STAGES)) u_cs (.clk(clk), .rst_n(rst_n), .d_i(spi_cs),
        .q_o(cs_q), .rise_o(cs_rise), .fall_o(cs_fall));
    spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sck (.clk(clk), .rst_n(rst_n), .d_i(spi_sck),
        .q_o(sck_q), .rise_o(sck_rise), .fall_o(sck_fall));
    spi_sync_edge #(.STAGES(SYNC_STAGES)) u_mosi (.clk(clk), .rst_n(rst_n), .d_i(spi_mosi),
        .q_o(mosi_q), .rise_o(mosi_rise), .fall_o(mosi_fall));

    state_t     state_q;
    logic [2:0] bit_cnt_q;
    logic [7:0] rx_q, tx_q, addr_q, led_q, blink_q, ctrl_q, frame_cnt_q;
    logic [7:0] rx_d, rd_data;
    logic [1:0] wr_addr_q;
    logic       rd_q, wr_strobe_q, miso_q, byte_done, wr_ok;

`ifdef SPI_REG_SLAVE_READBACK_EN
    localparam bit READBACK = 1'b1;
    assign spi_miso = miso_q;
`else
    localparam bit READBACK = 1'b0;
    assign spi_miso = 1'b0;
`endif

    always_comb begin
        rx_d      = {rx_q[6:0], mosi_q};
        byte_done = sck_rise && bit_cnt_q == 3'd7;
        wr_ok     = !rd_q && addr_q < ADDR_STATUS;
        rd_data   = rx_d == ADDR_LED    ? led_q :
                    rx_d == ADDR_BLINK  ? blink_q :
                    rx_d == ADDR_CTRL   ? ctrl_q :
                    rx_d == ADDR_STATUS ? frame_cnt_q : 8'h00;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= '0;
            rx_q        <= '0;
            tx_q        <= '0;
            addr_q      <= '0;
            rd_q        <= 1'b0;
            led_q       <= LED_RST;
            blink_q     <= BLINK_RST;
            ctrl_q      <= CTRL_RST;
            frame_cnt_q <= '0;
            wr_strobe_q <= 1'b0;
            wr_addr_q   <= '0;
            miso_q      <= 1'b0;
        end else begin
            wr_strobe_q <= 1'b0;
            if (cs_rise) begin
                state_q   <= ST_IDLE;
                bit_cnt_q <= '0;
                miso_q    <= 1'b0;
            end else begin
                if (state_q != ST_IDLE && sck_rise) begin
                    bit_cnt_q <= bit_cnt_q + 3'd1;
                    rx_q      <= rx_d;
                end
                case (state_q)
                    ST_IDLE: if (cs_fall) state_q <= ST_CMD;
                    ST_CMD: if (byte_done) begin
                        rd_q    <= READBACK && rx_d == CMD_READ;
                        state_q <= (rx_d == CMD_WRITE || (READBACK && rx_d == CMD_READ)) ? ST_ADDR : ST_HOLD;
                    end
                    ST_ADDR: if (byte_done) begin
                        addr_q  <= rx_d;
                        state_q <= ST_DATA;
                        if (rd_q) begin
                            tx_q   <= rd_data;
                            miso_q <= rd_data[7];
                        end
                    end
                    ST_DATA: if (byte_done) begin
                        state_q <= ST_HOLD;
                        miso_q  <= 1'b0;
                        if (wr_ok) begin
                            led_q       <= addr_q == ADDR_LED   ? rx_d : led_q;
                            blink_q     <= addr_q == ADDR_BLINK ? rx_d : blink_q;
                            ctrl_q      <= addr_q == ADDR_CTRL  ? rx_d : ctrl_q;
                            frame_cnt_q <= frame_cnt_q + 8'd1;
                            wr_strobe_q <= 1'b1;
                            wr_addr_q   <= addr_q[1:0];
                        end
                    // The fall right after the address byte is where the MSB is presented, so no shift.
                    end else if (rd_q && sck_fall && bit_cnt_q != 3'd0) begin
                        tx_q   <= {tx_q[6:0], 1'b0};
                        miso_q <= tx_q[6];
                    end
                    default: ;
                endcase
            end
        end
    end

    assign led_pattern = led_q;
    assign blink_div   = blink_q;
    assign ctrl        = ctrl_q;
    assign wr_strobe   = wr_strobe_q;
    assign wr_addr     = wr_addr_q;

    logic unused;
    assign unused = ^{cs_q, sck_q, mosi_rise, mosi_fall, miso_q, tx_q[7]};
endmodule

// File: tb/tb_spi_reg_slave.sv
// tb_spi_reg_slave: directed and random SPI frames checked against a register-map model.
module tb_spi_reg_slave;
    localparam logic [7:0] LED_RST = 8'h81;
`ifdef SPI_REG_SLAVE_READBACK_EN
    localparam bit RB = 1'b1;
`else
    localparam bit RB = 1'b0;
`endif

    logic clk = 1'b0, rst_n = 1'b0, spi_cs = 1'b1, spi_sck = 1'b0, spi_mosi = 1'b0;
    logic spi_miso, wr_strobe;
    logic [7:0] led_pattern, blink_div, ctrl;
    logic [1:0] wr_addr;

    spi_reg_slave #(.SYNC_STAGES(2), .LED_RST(LED_RST)) dut (
        .clk(clk), .rst_n(rst_n), .spi_cs(spi_cs), .spi_sck(spi_sck), .spi_mosi(spi_mosi),
        .spi_miso(spi_miso), .led_pattern(led_pattern), .blink_div(blink_div), .ctrl(ctrl),
        .wr_strobe(wr_strobe), .wr_addr(wr_addr));

    always #5 clk = ~clk;

    int vectors = 0, miscompares = 0, h = 8;
    int pulses = 0, hi_cyc = 0, exp_pulses = 0;
    logic prev_wr = 1'b0;
    logic [7:0] m_reg [3];
    logic [7:0] m_fc;
    logic [1:0] m_wa;

    always @(negedge clk) begin
        if (wr_strobe === 1'b1) begin
            hi_cyc++;
            if (prev_wr !== 1'b1) pulses++;
        end
        prev_wr = wr_strobe;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_reg[0] = LED_RST;
        m_reg[1] = 8'h19;
        m_reg[2] = 8'h01;
        m_fc = 8'h00;
        m_wa = 2'd0;
    endtask

    task automatic frame(input logic [23:0] d, input int nbits, input int rst_bit,
                         output logic [7:0] rbyte, output logic miso_any);
        rbyte = 8'h00;
        miso_any = 1'b0;
        spi_cs = 1'b0;
        repeat (h) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            spi_mosi = d[23-i];
            repeat (h) @(negedge clk);
            if (i >= 16) rbyte = {rbyte[6:0], spi_miso};
            else miso_any = miso_any | spi_miso;
            spi_sck = 1'b1;
            if (i == rst_bit) begin
                rst_n = 1'b0;
                repeat (2) @(negedge clk);
                rst_n = 1'b1;
            end
            repeat (h) @(negedge clk);
            spi_sck = 1'b0;
        end
        repeat (h) @(negedge clk);
        spi_cs = 1'b1;
        spi_mosi = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    task automatic run(input string tag, input logic [7:0] c, input logic [7:0] a, input logic [7:0] dd,
                       input int nbits, input int rst_bit, input bit full_chk);
        logic [7:0] rbyte, exp_rd;
        logic miso_any;
        exp_rd = (RB && nbits == 24 && c == 8'h02) ? (a < 3 ? m_reg[a[1:0]] : a == 3 ? m_fc : 8'h00) : 8'h00;
        frame({c, a, dd}, nbits, rst_bit, rbyte, miso_any);
        if (rst_bit >= 0) model_reset();
        else if (nbits == 24 && c == 8'h01 && a < 3) begin
            m_reg[a[1:0]] = dd;
            m_fc = m_fc + 8'd1;
            m_wa = a[1:0];
            exp_pulses++;
        end
        if (nbits == 24) chk({tag, " miso_data"}, rbyte, exp_rd);
        if (full_chk) begin
            chk({tag, " led"}, led_pattern, m_reg[0]);
            chk({tag, " blink"}, blink_div, m_reg[1]);
            chk({tag, " ctrl"}, ctrl, m_reg[2]);
            chk({tag, " wr_addr"}, wr_addr, m_wa);
            chk({tag, " strobes"}, pulses, exp_pulses);
            chk({tag, " strobe_cycles"}, hi_cyc, exp_pulses);
            chk({tag, " miso_idle"}, miso_any, 1'b0);
        end
    endtask

    initial begin
        logic [7:0] c, a, dd;
        int nb;
        model_reset();
        repeat (5) @(negedge clk);
        chk("rst led", led_pattern, LED_RST);
        chk("rst blink", blink_div, 8'h19);
        chk("rst ctrl", ctrl, 8'h01);
        chk("rst wr_strobe", wr_strobe, 1'b0);
        chk("rst wr_addr", wr_addr, 2'd0);
        chk("rst miso", spi_miso, 1'b0);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);

        run("wr_led", 8'h01, 8'h00, 8'hA5, 24, -1, 1);
        run("status1", 8'h02, 8'h03, 8'h00, 24, -1, 1);
        run("abort20", 8'h01, 8'h01, 8'h3C, 20, -1, 1);
        run("bad_cmd", 8'h07, 8'h02, 8'h55, 24, -1, 1);
        run("wr_ctrl", 8'h01, 8'h02, 8'h00, 24, -1, 1);
        run("wr_status", 8'h01, 8'h03, 8'h77, 24, -1, 1);
        run("wr_addr5", 8'h01, 8'h05, 8'h66, 24, -1, 1);
        run("wr_c3", 8'h01, 8'h00, 8'hC3, 24, -1, 1);
        run("rd_led", 8'h02, 8'h00, 8'h00, 24, -1, 1);
        run("rd_addr6", 8'h02, 8'h06, 8'h00, 24, -1, 1);

        for (int i = 0; i < 24; i++) begin
            case ($urandom_range(0, 3))
                0, 1:    c = 8'h01;
                2:       c = 8'h02;
                default: c = 8'($urandom_range(3, 255));
            endcase
            a = 8'($urandom_range(0, 5));
            dd = 8'($urandom);
            nb = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 23)) : 24;
            run("rand", c, a, dd, nb, -1, 1);
        end

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        repeat (10) @(negedge clk);
        h = 4;
        for (int i = 0; i < 256; i++) run("wrap_wr", 8'h01, 8'h01, 8'(i), 24, -1, 0);
        h = 8;
        run("wrap_rd", 8'h02, 8'h03, 8'h00, 24, -1, 1);

        run("wr_pre", 8'h01, 8'h00, 8'h3E, 24, -1, 1);
        run("rst_mid", 8'h01, 8'h00, 8'hFF, 24, 20, 1);
        run("after_rst", 8'h01, 8'h00, 8'h0F, 24, -1, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/spi_reg_slave.md
SPI_REG_SLAVE -- requirements
Module: spi_reg_slave

Interface
REQ-001 Parameter SYNC_STAGES, default 2: synchronizer depth for spi_cs, spi_sck and spi_mosi, legal range 2-3.
REQ-002 Parameter LED_RST, default 8'h01: reset value of the LED_PATTERN register.
REQ-003 clk  input  1  system clock, 27 MHz; the only clock, and all logic is clocked on its rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 spi_cs  input  1  SPI chip select, active low, asynchronous to clk.
REQ-006 spi_sck  input  1  SPI clock, mode 0, maximum clk/8, asynchronous to clk.
REQ-007 spi_mosi  input  1  serial data from the ESP32, MSB first.
REQ-008 spi_miso  output  1  serial data to the ESP32, MSB first.
REQ-009 led_pattern  output  8  LED_PATTERN register value, consumed by the blinker.
REQ-010 blink_div  output  8  BLINK_DIV register value (blink rate select).
REQ-011 ctrl  output  8  CTRL register value (bit0 = rotate enable).
REQ-012 wr_strobe  output  1  one-cycle pulse on each committed register write.
REQ-013 wr_addr  output  2  address of the last committed write.

Function
REQ-014 spi_cs, spi_sck and spi_mosi shall each pass through SYNC_STAGES flops; sck rise and fall events and the cs falling and rising events shall be detected in the clk domain.
REQ-015 Bytes shall assemble MSB first, sampling the synchronized MOSI on each sck rise; a byte completes on its 8th rise.
REQ-016 FSM states: IDLE, CMD, ADDR, DATA, HOLD; IDLE->CMD on cs fall; CMD->ADDR on completion of a byte equal to 8'h01 (WRITE) or 8'h02 (READ); CMD->HOLD on any other command byte.
REQ-017 ADDR->DATA on byte completion; DATA->HOLD on byte completion; any state->IDLE on cs rise, clearing the bit counter.
REQ-018 WRITE: on completion of the DATA byte, the addressed register shall update on the next clk edge, with wr_strobe high for exactly that cycle and wr_addr set to the address.
REQ-019 Register map: 0 LED_PATTERN (RW, reset LED_RST); 1 BLINK_DIV (RW, reset 8'h19); 2 CTRL (RW, reset 8'h01); 3 STATUS (RO, equal to frame_cnt).
REQ-020 Writes to address 3, or to an address at or above 4, shall be dropped with no wr_strobe; reads of an address at or above 4 shall return 8'h00.
REQ-021 A cs rise before the DATA byte completes shall abort the frame: no register change and no wr_strobe.
REQ-022 frame_cnt (8 bit) shall increment on every committed write and wrap 8'hFF->8'h00.
REQ-023 Bytes clocked in while in HOLD shall be ignored until cs rises.
REQ-024 spi_miso shall be 0 whenever no read data is being shifted.

Reset
REQ-025 rst_n low shall asynchronously force: FSM to IDLE, bit counter and shift registers to 0, LED_PATTERN=LED_RST, BLINK_DIV=8'h19, CTRL=8'h01, frame_cnt=0, wr_strobe=0, wr_addr=0, spi_miso=0.
REQ-026 Reset asserted mid-frame shall discard the frame; after release, the block shall act only on the next cs fall.

Configuration
REQ-027 Macro SPI_REG_SLAVE_READBACK_EN defined: READ shall load the addressed register into the TX shift register on ADDR-byte completion, drive its MSB on spi_miso within 2 clk cycles, and advance one bit per sck fall.
REQ-028 Macro SPI_REG_SLAVE_READBACK_EN undefined: READ shall be treated as an unknown command (CMD->HOLD), and spi_miso shall be tied to 0.

Structure
REQ-029 Package spi_reg_pkg shall hold the command codes, register addresses, register reset values (except LED_RST) and the FSM state enum.
REQ-030 Sub-module spi_sync_edge shall contain one SYNC_STAGES-deep synchronizer plus its rise and fall pulse outputs, instantiated once per SPI input.

Verification
REQ-031 Frame 01 00 A5 -> led_pattern=8'hA5, one wr_strobe pulse with wr_addr=0, frame_cnt=1.
REQ-032 Frame 01 01 3C with cs raised after 20 bits -> blink_div stays 8'h19, no wr_strobe.
REQ-033 Frame 07 02 55 -> ctrl stays 8'h01, no wr_strobe; a following frame 01 02 00 -> ctrl=8'h00.
REQ-034 With READBACK_EN: frame 02 00 xx after LED_PATTERN=8'hC3 -> 8'hC3 on miso in the third byte; with the macro undefined -> miso=0 throughout.
REQ-035 256 writes to address 1 -> frame_cnt wraps to 8'h00; a read of address 3 returns 8'h00.
REQ-036 rst_n pulsed low during the DATA byte of 01 00 FF -> led_pattern=LED_RST; the next full frame 01 00 0F -> led_pattern=8'h0F.
